// File: rtl/bus_serializer_if.sv
// Core-side request/response and pad-side beat signals of the address/data serializer.
// The slave modport is the serializer; the master modport is the core plus the pad ring.
interface bus_serializer_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int PAD_W  = 8
) ();
  localparam int NA   = (ADDR_W + PAD_W - 1) / PAD_W;
  localparam int ND   = (DATA_W + PAD_W - 1) / PAD_W;
  localparam int NM   = (NA > ND) ? NA : ND;
  localparam int MAXB = (NM > 2) ? NM : 2;
  localparam int BW   = $clog2(MAXB);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              pad_rdy;
  logic [PAD_W-1:0]  pad_out;
  logic              pad_oe;
  logic [PAD_W-1:0]  pad_in;
  logic [1:0]        phase;
  logic [BW-1:0]     beat;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, pad_rdy, pad_in,
    output req_ready, rsp_valid, rsp_rdata, pad_out, pad_oe, phase, beat
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, pad_rdy, pad_in,
    input  req_ready, rsp_valid, rsp_rdata, pad_out, pad_oe, phase, beat
  );
endinterface

// File: rtl/bus_serializer.sv
// Splits a core bus request into pad-width beats: address beats LSB first, then
// write-data beats driven out or read-data beats sampled in, each gated by pad_rdy.
module bus_serializer #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int PAD_W  = 8
) (
  input logic             clk,
  input logic             reset,
  bus_serializer_if.slave bus
);
  localparam int NA   = (ADDR_W + PAD_W - 1) / PAD_W;
  localparam int ND   = (DATA_W + PAD_W - 1) / PAD_W;
  localparam int NM   = (NA > ND) ? NA : ND;
  localparam int MAXB = (NM > 2) ? NM : 2;
  localparam int BW   = $clog2(MAXB);
  localparam int AP   = NA * PAD_W;
  localparam int DP   = ND * PAD_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADDR  = 2'd1,
    S_WDATA = 2'd2,
    S_RDATA = 2'd3
  } state_t;

  localparam logic [1:0] PH_ADDR  = 2'd0;
  localparam logic [1:0] PH_WDATA = 2'd1;
  localparam logic [1:0] PH_RDATA = 2'd2;
  localparam logic [1:0] PH_IDLE  = 2'd3;

  state_t            state_q, state_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [PAD_W-1:0]  pad_out_q, pad_out_d;
  logic              pad_oe_q, pad_oe_d;
  logic [1:0]        phase_q, phase_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [AP-1:0]     addr_q, addr_d;
  logic [DP-1:0]     wdata_q, wdata_d;
  logic [DP-1:0]     rdata_q, rdata_d;
  logic              we_q, we_d;
  logic              last_addr_s;
  logic              last_data_s;

  // Latched operands are stored zero-extended to whole beats, so slices past the
  // configured width naturally drive zeros.
  function automatic logic [PAD_W-1:0] addr_slice(input logic [AP-1:0] v, input logic [BW-1:0] b);
    return v[int'(b) * PAD_W +: PAD_W];
  endfunction

  function automatic logic [PAD_W-1:0] data_slice(input logic [DP-1:0] v, input logic [BW-1:0] b);
    return v[int'(b) * PAD_W +: PAD_W];
  endfunction

  assign last_addr_s = (beat_q == BW'(NA - 1));
  assign last_data_s = (beat_q == BW'(ND - 1));

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.pad_out   = pad_out_q;
  assign bus.pad_oe    = pad_oe_q;
  assign bus.phase     = phase_q;
  assign bus.beat      = beat_q;

  // Next-state and next-output computation; outputs are set one cycle ahead.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    pad_out_d   = pad_out_q;
    pad_oe_d    = pad_oe_q;
    phase_d     = phase_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    we_d        = we_q;
    case (state_q)
      S_IDLE: begin
        beat_d    = {BW{1'b0}};
        pad_out_d = {PAD_W{1'b0}};
        pad_oe_d  = 1'b0;
        phase_d   = PH_IDLE;
        if (bus.req_valid) begin
          addr_d    = AP'(bus.req_addr);
          wdata_d   = DP'(bus.req_wdata);
          we_d      = bus.req_we;
          rdata_d   = {DP{1'b0}};
          state_d   = S_ADDR;
          pad_out_d = addr_slice(AP'(bus.req_addr), {BW{1'b0}});
          pad_oe_d  = 1'b1;
          phase_d   = PH_ADDR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADDR: begin
        if (bus.pad_rdy) begin
          if (last_addr_s) begin
            beat_d = {BW{1'b0}};
            if (we_q) begin
              state_d   = S_WDATA;
              pad_out_d = data_slice(wdata_q, {BW{1'b0}});
              pad_oe_d  = 1'b1;
              phase_d   = PH_WDATA;
            end else begin
              state_d   = S_RDATA;
              pad_out_d = {PAD_W{1'b0}};
              pad_oe_d  = 1'b0;
              phase_d   = PH_RDATA;
            end
          end else begin
            beat_d    = beat_q + BW'(1);
            pad_out_d = addr_slice(addr_q, beat_q + BW'(1));
          end
        end else begin
          state_d = S_ADDR;
        end
      end
      S_WDATA: begin
        if (bus.pad_rdy) begin
          if (last_data_s) begin
            state_d     = S_IDLE;
            beat_d      = {BW{1'b0}};
            pad_out_d   = {PAD_W{1'b0}};
            pad_oe_d    = 1'b0;
            phase_d     = PH_IDLE;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = {DATA_W{1'b0}};
          end else begin
            beat_d    = beat_q + BW'(1);
            pad_out_d = data_slice(wdata_q, beat_q + BW'(1));
          end
        end else begin
          state_d = S_WDATA;
        end
      end
      S_RDATA: begin
        if (bus.pad_rdy) begin
          rdata_d[int'(beat_q) * PAD_W +: PAD_W] = bus.pad_in;
          if (last_data_s) begin
            state_d     = S_IDLE;
            beat_d      = {BW{1'b0}};
            pad_out_d   = {PAD_W{1'b0}};
            pad_oe_d    = 1'b0;
            phase_d     = PH_IDLE;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = rdata_d[DATA_W-1:0];
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end else begin
          state_d = S_RDATA;
        end
      end
      default: begin
        state_d   = S_IDLE;
        beat_d    = {BW{1'b0}};
        pad_out_d = {PAD_W{1'b0}};
        pad_oe_d  = 1'b0;
        phase_d   = PH_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction without a response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      beat_q      <= {BW{1'b0}};
      pad_out_q   <= {PAD_W{1'b0}};
      pad_oe_q    <= 1'b0;
      phase_q     <= PH_IDLE;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= {DATA_W{1'b0}};
      addr_q      <= {AP{1'b0}};
      wdata_q     <= {DP{1'b0}};
      rdata_q     <= {DP{1'b0}};
      we_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      pad_out_q   <= pad_out_d;
      pad_oe_q    <= pad_oe_d;
      phase_q     <= phase_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      we_q        <= we_d;
    end
  end
endmodule

// File: tb/tb_bus_serializer.sv
// Directed bench: default 16/8/8 serializer plus a 10/8/4 variant for multi-beat data phases.
module tb_bus_serializer;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  bus_serializer_if #(.ADDR_W(16), .DATA_W(8), .PAD_W(8)) ia ();
  bus_serializer_if #(.ADDR_W(10), .DATA_W(8), .PAD_W(4)) ib ();

  bus_serializer #(.ADDR_W(16), .DATA_W(8), .PAD_W(8)) dut_a (.clk(clk), .reset(reset), .bus(ia));
  bus_serializer #(.ADDR_W(10), .DATA_W(8), .PAD_W(4)) dut_b (.clk(clk), .reset(reset), .bus(ib));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_a(input string tag, input int ph, input int bt, input int po, input int oe);
    chk({tag, "_phase"}, 32'(ia.phase), ph);
    chk({tag, "_beat"}, 32'(ia.beat), bt);
    chk({tag, "_pad_out"}, 32'(ia.pad_out), po);
    chk({tag, "_pad_oe"}, 32'(ia.pad_oe), oe);
  endtask

  task automatic chk_b(input string tag, input int ph, input int bt, input int po, input int oe);
    chk({tag, "_phase"}, 32'(ib.phase), ph);
    chk({tag, "_beat"}, 32'(ib.beat), bt);
    chk({tag, "_pad_out"}, 32'(ib.pad_out), po);
    chk({tag, "_pad_oe"}, 32'(ib.pad_oe), oe);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    ia.req_valid = 1'b0; ia.req_we = 1'b0; ia.req_addr = 16'h0; ia.req_wdata = 8'h0;
    ia.pad_rdy = 1'b0; ia.pad_in = 8'h0;
    ib.req_valid = 1'b0; ib.req_we = 1'b0; ib.req_addr = 10'h0; ib.req_wdata = 8'h0;
    ib.pad_rdy = 1'b0; ib.pad_in = 4'h0;

    // reset then idle
    step(); step();
    chk("rst_ready", 32'(ia.req_ready), 1);
    chk("rst_rsp", 32'(ia.rsp_valid), 0);
    chk("rst_rdata", 32'(ia.rsp_rdata), 0);
    chk_a("rst", 3, 0, 8'h00, 0);
    chk("rst_b_ready", 32'(ib.req_ready), 1);
    reset = 1'b0;
    step();
    chk_a("idle", 3, 0, 8'h00, 0);

    // write 0xBEEF / 0x5A, pad_rdy high throughout
    ia.req_valid = 1'b1; ia.req_we = 1'b1; ia.req_addr = 16'hBEEF; ia.req_wdata = 8'h5A;
    ia.pad_rdy = 1'b1;
    step();
    ia.req_valid = 1'b0;
    chk("wr_ready_busy", 32'(ia.req_ready), 0);
    chk_a("wr_a0", 0, 0, 8'hEF, 1);
    step();
    chk_a("wr_a1", 0, 1, 8'hBE, 1);
    step();
    chk_a("wr_d0", 1, 0, 8'h5A, 1);
    chk("wr_no_rsp_yet", 32'(ia.rsp_valid), 0);
    step();
    chk("wr_rsp", 32'(ia.rsp_valid), 1);
    chk("wr_rdata", 32'(ia.rsp_rdata), 0);
    chk_a("wr_idle", 3, 0, 8'h00, 0);
    chk("wr_ready_back", 32'(ia.req_ready), 1);
    step();
    chk("wr_rsp_pulse", 32'(ia.rsp_valid), 0);

    // read 0x1234 with a three-cycle stall on address beat 0
    ia.req_valid = 1'b1; ia.req_we = 1'b0; ia.req_addr = 16'h1234; ia.pad_rdy = 1'b0;
    ia.pad_in = 8'hFF;
    step();
    ia.req_valid = 1'b0;
    chk_a("rd_a0", 0, 0, 8'h34, 1);
    for (int i = 0; i < 2; i++) begin
      step();
      chk_a("rd_stall", 0, 0, 8'h34, 1);
    end
    ia.pad_rdy = 1'b1;
    step();
    chk_a("rd_a1", 0, 1, 8'h12, 1);
    step();
    chk_a("rd_d0", 2, 0, 8'h00, 0);
    ia.pad_in = 8'hC3;
    step();
    chk("rd_rsp", 32'(ia.rsp_valid), 1);
    chk("rd_rdata", 32'(ia.rsp_rdata), 8'hC3);
    ia.pad_in = 8'h00;
    step();
    chk("rd_rsp_pulse", 32'(ia.rsp_valid), 0);
    chk("rd_rdata_hold", 32'(ia.rsp_rdata), 8'hC3);

    // back-to-back reads: second request waits with req_valid held high
    ia.req_valid = 1'b1; ia.req_we = 1'b0; ia.req_addr = 16'h1111; ia.pad_in = 8'h11;
    step();
    ia.req_addr = 16'h2222;
    chk_a("b2b_a0", 0, 0, 8'h11, 1);
    step();
    chk_a("b2b_a1", 0, 1, 8'h11, 1);
    step();
    chk_a("b2b_d0", 2, 0, 8'h00, 0);
    step();
    chk("b2b_rsp1", 32'(ia.rsp_valid), 1);
    chk("b2b_rdata1", 32'(ia.rsp_rdata), 8'h11);
    chk("b2b_ready", 32'(ia.req_ready), 1);
    step();
    ia.req_valid = 1'b0;
    chk_a("b2b2_a0", 0, 0, 8'h22, 1);
    chk("b2b2_rsp_low", 32'(ia.rsp_valid), 0);
    step();
    chk_a("b2b2_a1", 0, 1, 8'h22, 1);
    step();
    chk_a("b2b2_d0", 2, 0, 8'h00, 0);
    ia.pad_in = 8'h44;
    step();
    chk("b2b_rsp2", 32'(ia.rsp_valid), 1);
    chk("b2b_rdata2", 32'(ia.rsp_rdata), 8'h44);
    step();

    // reset asserted during the write-data beat
    ia.req_valid = 1'b1; ia.req_we = 1'b1; ia.req_addr = 16'h0102; ia.req_wdata = 8'h77;
    step();
    ia.req_valid = 1'b0;
    step();
    step();
    chk_a("mid_d0", 1, 0, 8'h77, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_oe_async", 32'(ia.pad_oe), 0);
    chk("mid_pad_async", 32'(ia.pad_out), 0);
    step();
    chk("mid_no_rsp", 32'(ia.rsp_valid), 0);
    chk("mid_rdata_clr", 32'(ia.rsp_rdata), 0);
    chk_a("mid_rst", 3, 0, 8'h00, 0);
    reset = 1'b0;
    step();
    chk("mid_no_rsp2", 32'(ia.rsp_valid), 0);
    ia.req_valid = 1'b1; ia.req_we = 1'b1; ia.req_addr = 16'hA0B1; ia.req_wdata = 8'hC2;
    step();
    ia.req_valid = 1'b0;
    chk_a("post_a0", 0, 0, 8'hB1, 1);
    step();
    chk_a("post_a1", 0, 1, 8'hA0, 1);
    step();
    chk_a("post_d0", 1, 0, 8'hC2, 1);
    step();
    chk("post_rsp", 32'(ia.rsp_valid), 1);
    ia.pad_rdy = 1'b0;

    // narrow pad: write 0x3A5 / 0x96 in nibbles
    ib.req_valid = 1'b1; ib.req_we = 1'b1; ib.req_addr = 10'h3A5; ib.req_wdata = 8'h96;
    ib.pad_rdy = 1'b1;
    step();
    ib.req_valid = 1'b0;
    chk_b("n_wr_a0", 0, 0, 4'h5, 1);
    step();
    chk_b("n_wr_a1", 0, 1, 4'hA, 1);
    step();
    chk_b("n_wr_a2", 0, 2, 4'h3, 1);
    step();
    chk_b("n_wr_d0", 1, 0, 4'h6, 1);
    step();
    chk_b("n_wr_d1", 1, 1, 4'h9, 1);
    step();
    chk("n_wr_rsp", 32'(ib.rsp_valid), 1);
    chk("n_wr_rdata", 32'(ib.rsp_rdata), 0);

    // narrow pad: read assembling 0x7 then 0xE
    ib.req_valid = 1'b1; ib.req_we = 1'b0; ib.req_addr = 10'h0C1;
    step();
    ib.req_valid = 1'b0;
    chk_b("n_rd_a0", 0, 0, 4'h1, 1);
    step();
    chk_b("n_rd_a1", 0, 1, 4'hC, 1);
    step();
    chk_b("n_rd_a2", 0, 2, 4'h0, 1);
    step();
    chk_b("n_rd_d0", 2, 0, 4'h0, 0);
    ib.pad_in = 4'h7;
    step();
    chk_b("n_rd_d1", 2, 1, 4'h0, 0);
    chk("n_rd_no_rsp", 32'(ib.rsp_valid), 0);
    ib.pad_in = 4'hE;
    step();
    chk("n_rd_rsp", 32'(ib.rsp_valid), 1);
    chk("n_rd_rdata", 32'(ib.rsp_rdata), 8'hE7);
    ib.pad_rdy = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bus_serializer.md
Name: bus_serializer

Overview:
- Parametrised address/data serializer between the CPU core bus and a narrow pad bus.
- Each request is split into pad-width beats: address beats first, then either write-data beats driven out or read-data beats sampled in.
- Each beat advances only when the external pad_rdy strobe is high.
- Sits between the core and the chip I/O ring; supports reads and writes of any configured width.

Parameters:
ADDR_W, 16, request address width (>=1)
DATA_W, 8, request data width (>=1)
PAD_W, 8, pad bus width (>=1)
Derived (localparam): NA = ceil(ADDR_W/PAD_W), ND = ceil(DATA_W/PAD_W), BW = clog2(max(NA,ND,2))

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  core request present
req_ready  out  1  block can accept a request (combinational: state==IDLE)
req_we  in  1  1=write, 0=read
req_addr  in  ADDR_W  request address
req_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle pulse: transaction complete
rsp_rdata  out  DATA_W  assembled read data, valid with rsp_valid on reads; 0 on writes
pad_rdy  in  1  external beat-accept strobe
pad_out  out  PAD_W  outgoing beat
pad_oe  out  1  pad output enable
pad_in  in  PAD_W  incoming read beat
phase  out  2  0=address, 1=write data, 2=read data, 3=idle
beat  out  BW  index of current beat within its phase

Behaviour:
- Reset (async, active-high):
  - state=IDLE, phase=3, beat=0, pad_out=0, pad_oe=0, rsp_valid=0, rsp_rdata=0.
  - All latched request registers cleared.
- All outputs except req_ready are registered.
- States: IDLE, ADDR, WDATA, RDATA.
- IDLE:
  - pad_oe=0, pad_out=0, phase=3.
  - On req_valid&req_ready: latch addr, wdata and we; go to ADDR with beat=0.
  - The first address beat appears on pad_out the cycle after acceptance.
- ADDR:
  - pad_out = addr[beat*PAD_W +: PAD_W], LSB slice first.
  - Bits above ADDR_W are driven 0.
  - pad_oe=1, phase=0.
  - pad_rdy=0: hold beat and pad_out, with no timeout.
  - pad_rdy=1 and beat<NA-1: beat+1.
  - pad_rdy=1 and beat==NA-1: go to WDATA if we=1, else RDATA, with beat=0.
- WDATA:
  - pad_out = wdata slice, same slicing and zero-pad rule as ADDR.
  - pad_oe=1, phase=1.
  - Advances on pad_rdy.
  - On the last beat with pad_rdy: next cycle rsp_valid=1, rsp_rdata=0, state=IDLE.
- RDATA:
  - pad_oe=0, pad_out=0, phase=2.
  - On pad_rdy: capture pad_in into rdata[beat*PAD_W +: PAD_W]. Bits beyond DATA_W are discarded.
  - On the last beat with pad_rdy: next cycle rsp_valid=1 and rsp_rdata = assembled value (including the final beat); state=IDLE.
- Single-beat phases (NA==1 or ND==1): the phase lasts exactly one accepted beat.
- Minimum transaction length: 1 accept cycle + NA + ND cycles when pad_rdy is held high.
  - rsp_valid coincides with the IDLE cycle.
  - A new request may be accepted in that same cycle.
- rsp_rdata holds its value until the next rsp_valid.
- Request inputs are ignored outside IDLE; the latched copies are used.
- Reset mid-transaction: abort immediately, no rsp_valid, pad_oe drops asynchronously.
- pad_in is ignored outside RDATA or when pad_rdy=0.

Test Plan:
- Reset then idle: reset=1 for 2 cycles -> req_ready=1, phase=3, pad_oe=0, pad_out=0x00, rsp_valid=0.
- Write, default params, pad_rdy=1 throughout:
  - Stimulus: addr=0xBEEF, wdata=0x5A, we=1.
  - Required pad_out sequence: 0xEF (phase 0, beat 0), 0xBE (phase 0, beat 1), 0x5A (phase 1).
  - Then rsp_valid pulse with rsp_rdata=0; total 4 cycles from acceptance.
- Read with stalls:
  - Stimulus: addr=0x1234, we=0; pad_rdy low for 3 cycles during beat 0.
  - Required: pad_out holds 0x34 across the stall.
  - After the address beats: pad_oe=0; pad_in=0xC3 with pad_rdy -> rsp_valid, rsp_rdata=0xC3.
- PAD_W=4, ADDR_W=10, DATA_W=8:
  - Write addr=0x3A5, wdata=0x96.
  - Required pad_out: 0x5, 0xA, 0x3 (top 2 bits zero), 0x6, 0x9.
  - Read with pad_in 0x7 then 0xE -> rsp_rdata=0x E7.
- Back-to-back: hold req_valid=1 with a second read queued -> accepted in the same cycle as the first rsp_valid; the second transaction's address beat 0 appears the next cycle.
- Reset mid-write: assert reset during WDATA -> pad_oe=0 immediately, no rsp_valid, next request serializes normally from beat 0.
